// File: rtl/mano_datapath.sv
// Register-transfer datapath of the 8-bit basic computer.
// Executes control-unit strobes on AR, PC, DR, AC, IR, E and the one-hot
// sequence counter, and drives the common bus and the external memory port.
module mano_datapath #(
  parameter int unsigned WORD_W   = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned PC_RESET = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LDAR,
  input  logic              CLRAR,
  input  logic              INCAR,
  input  logic              LDPC,
  input  logic              CLRPC,
  input  logic              INCPC,
  input  logic              LDDR,
  input  logic              CLRDR,
  input  logic              INCDR,
  input  logic              LDIR,
  input  logic              CLRIR,
  input  logic              INCIR,
  input  logic              LDAC,
  input  logic              CLRAC,
  input  logic              INCAC,
  input  logic              AND,
  input  logic              ADD,
  input  logic              LDA,
  input  logic              COM,
  input  logic              CLRSEQ,
  input  logic              INCSEQ,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [7:0]        I,
  input  logic [WORD_W-1:0] MEM_RDATA,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [WORD_W-1:0] MEM_WDATA,
  output logic              MEM_RE,
  output logic              MEM_WE,
  output logic [7:0]        T,
  output logic [7:0]        D,
  output logic [WORD_W-1:0] IR_Q,
  output logic [WORD_W-1:0] AC_Q,
  output logic              E,
  output logic              BUS_CONFLICT
);

  logic [ADDR_W-1:0] ar_q;
  logic [ADDR_W-1:0] pc_q;
  logic [WORD_W-1:0] dr_q;
  logic [WORD_W-1:0] ac_q;
  logic [WORD_W-1:0] ir_q;
  logic              e_q;
  logic [7:0]        t_q;
  logic [WORD_W-1:0] bus;
  logic [WORD_W:0]   sum;

  // Common bus: highest set select bit wins; I[6] and I[0] source zero
  always_comb begin
    bus = '0;
    if (I[7])      bus = MEM_RDATA;
    else if (I[6]) bus = '0;
    else if (I[5]) bus = ir_q;
    else if (I[4]) bus = ac_q;
    else if (I[3]) bus = dr_q;
    else if (I[2]) bus = WORD_W'(pc_q);
    else if (I[1]) bus = WORD_W'(ar_q);
  end

  // More than one select bit set: clearing the lowest set bit leaves something
  assign BUS_CONFLICT = |(I & (I - 8'd1));

  assign sum = {1'b0, ac_q} + {1'b0, dr_q};

  // AR: clear > load > increment
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        ar_q <= '0;
    else if (CLRAR) ar_q <= '0;
    else if (LDAR)  ar_q <= bus[ADDR_W-1:0];
    else if (INCAR) ar_q <= ar_q + 1'b1;
  end

  // PC: clear > load > increment
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        pc_q <= ADDR_W'(PC_RESET);
    else if (CLRPC) pc_q <= '0;
    else if (LDPC)  pc_q <= bus[ADDR_W-1:0];
    else if (INCPC) pc_q <= pc_q + 1'b1;
  end

  // DR: clear > load > increment
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        dr_q <= '0;
    else if (CLRDR) dr_q <= '0;
    else if (LDDR)  dr_q <= bus;
    else if (INCDR) dr_q <= dr_q + 1'b1;
  end

  // IR: clear > load > increment
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        ir_q <= '0;
    else if (CLRIR) ir_q <= '0;
    else if (LDIR)  ir_q <= bus;
    else if (INCIR) ir_q <= ir_q + 1'b1;
  end

  // AC and E: only the highest-priority op acts; E moves only on ADD
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ac_q <= '0;
      e_q  <= 1'b0;
    end else if (CLRAC) begin
      ac_q <= '0;
    end else if (LDAC) begin
      ac_q <= bus;
    end else if (AND) begin
      ac_q <= ac_q & dr_q;
    end else if (ADD) begin
      ac_q <= sum[WORD_W-1:0];
      e_q  <= sum[WORD_W];
    end else if (LDA) begin
      ac_q <= dr_q;
    end else if (COM) begin
      ac_q <= ~ac_q;
    end else if (INCAC) begin
      ac_q <= ac_q + 1'b1;
    end
  end

  // Sequence counter: one-hot rotate, clear wins over advance
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         t_q <= 8'h01;
    else if (CLRSEQ) t_q <= 8'h01;
    else if (INCSEQ) t_q <= {t_q[6:0], t_q[7]};
  end

  // Opcode decode of IR[6:4]
  always_comb begin
    D = '0;
    D[ir_q[6:4]] = 1'b1;
  end

  assign MEM_ADDR  = ar_q;
  assign MEM_WDATA = bus;
  assign MEM_RE    = READ;
  assign MEM_WE    = WRITE;
  assign T         = t_q;
  assign IR_Q      = ir_q;
  assign AC_Q      = ac_q;
  assign E         = e_q;

endmodule

// File: tb/tb_mano_datapath.sv
// Self-checking bench for mano_datapath: directed test-plan sequences plus
// randomized strobes, all checked every cycle against a behavioural model.
module tb_mano_datapath;

  localparam logic [22:0] SLdar   = 23'd1 << 0;
  localparam logic [22:0] SClrar  = 23'd1 << 1;
  localparam logic [22:0] SIncar  = 23'd1 << 2;
  localparam logic [22:0] SLdpc   = 23'd1 << 3;
  localparam logic [22:0] SClrpc  = 23'd1 << 4;
  localparam logic [22:0] SIncpc  = 23'd1 << 5;
  localparam logic [22:0] SLddr   = 23'd1 << 6;
  localparam logic [22:0] SClrdr  = 23'd1 << 7;
  localparam logic [22:0] SIncdr  = 23'd1 << 8;
  localparam logic [22:0] SLdir   = 23'd1 << 9;
  localparam logic [22:0] SClrir  = 23'd1 << 10;
  localparam logic [22:0] SIncir  = 23'd1 << 11;
  localparam logic [22:0] SLdac   = 23'd1 << 12;
  localparam logic [22:0] SClrac  = 23'd1 << 13;
  localparam logic [22:0] SIncac  = 23'd1 << 14;
  localparam logic [22:0] SAnd    = 23'd1 << 15;
  localparam logic [22:0] SAdd    = 23'd1 << 16;
  localparam logic [22:0] SLda    = 23'd1 << 17;
  localparam logic [22:0] SCom    = 23'd1 << 18;
  localparam logic [22:0] SClrseq = 23'd1 << 19;
  localparam logic [22:0] SIncseq = 23'd1 << 20;
  localparam logic [22:0] SRead   = 23'd1 << 21;
  localparam logic [22:0] SWrite  = 23'd1 << 22;

  logic        CLK;
  logic        RST;
  logic [22:0] st;
  logic [7:0]  I;
  logic [7:0]  MEM_RDATA;
  logic [3:0]  MEM_ADDR;
  logic [7:0]  MEM_WDATA;
  logic        MEM_RE;
  logic        MEM_WE;
  logic [7:0]  T;
  logic [7:0]  D;
  logic [7:0]  IR_Q;
  logic [7:0]  AC_Q;
  logic        E;
  logic        BUS_CONFLICT;

  logic [7:0] mem [16];
  assign MEM_RDATA = mem[MEM_ADDR];

  int checks = 0;
  int errors = 0;

  // Behavioural model state (plain integers)
  int m_ar, m_pc, m_dr, m_ac, m_ir, m_e, m_t;

  mano_datapath #(.WORD_W(8), .ADDR_W(4), .PC_RESET(0)) dut (
    .CLK(CLK), .RST(RST),
    .LDAR(st[0]), .CLRAR(st[1]), .INCAR(st[2]),
    .LDPC(st[3]), .CLRPC(st[4]), .INCPC(st[5]),
    .LDDR(st[6]), .CLRDR(st[7]), .INCDR(st[8]),
    .LDIR(st[9]), .CLRIR(st[10]), .INCIR(st[11]),
    .LDAC(st[12]), .CLRAC(st[13]), .INCAC(st[14]),
    .AND(st[15]), .ADD(st[16]), .LDA(st[17]), .COM(st[18]),
    .CLRSEQ(st[19]), .INCSEQ(st[20]),
    .READ(st[21]), .WRITE(st[22]),
    .I(I), .MEM_RDATA(MEM_RDATA),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE),
    .T(T), .D(D), .IR_Q(IR_Q), .AC_Q(AC_Q), .E(E), .BUS_CONFLICT(BUS_CONFLICT)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ar = 0; m_pc = 0; m_dr = 0; m_ac = 0; m_ir = 0; m_e = 0; m_t = 0;
  endtask

  // Bus value from the select rule: the highest set index names the source
  function automatic int mbus(input logic [7:0] isel);
    int w = -1;
    for (int k = 0; k < 8; k++) if (isel[k]) w = k;
    case (w)
      1: return m_ar;
      2: return m_pc;
      3: return m_dr;
      4: return m_ac;
      5: return m_ir;
      7: return int'(mem[m_ar]);
      default: return 0;
    endcase
  endfunction

  // One clock cycle: drive, check all outputs pre-edge, advance model after edge
  task automatic run(input logic [22:0] s, input logic [7:0] isel);
    int b, n_ar, n_pc, n_dr, n_ir, n_ac, n_e, n_t, sum, wa;
    st = s;
    I  = isel;
    #1;
    b = mbus(isel);
    chk("bus", int'(MEM_WDATA), b);
    chk("bus_conflict", int'(BUS_CONFLICT), int'($countones(isel) > 1));
    chk("mem_addr", int'(MEM_ADDR), m_ar);
    chk("mem_re", int'(MEM_RE), int'(s[21]));
    chk("mem_we", int'(MEM_WE), int'(s[22]));
    chk("t", int'(T), 1 << m_t);
    chk("d", int'(D), 1 << ((m_ir / 16) % 8));
    chk("ir", int'(IR_Q), m_ir);
    chk("ac", int'(AC_Q), m_ac);
    chk("e", int'(E), m_e);

    n_ar = (s & SClrar) != 0 ? 0 : (s & SLdar) != 0 ? b % 16 : (s & SIncar) != 0 ? (m_ar + 1) % 16 : m_ar;
    n_pc = (s & SClrpc) != 0 ? 0 : (s & SLdpc) != 0 ? b % 16 : (s & SIncpc) != 0 ? (m_pc + 1) % 16 : m_pc;
    n_dr = (s & SClrdr) != 0 ? 0 : (s & SLddr) != 0 ? b : (s & SIncdr) != 0 ? (m_dr + 1) % 256 : m_dr;
    n_ir = (s & SClrir) != 0 ? 0 : (s & SLdir) != 0 ? b : (s & SIncir) != 0 ? (m_ir + 1) % 256 : m_ir;
    n_e  = m_e;
    sum  = m_ac + m_dr;
    if ((s & SClrac) != 0)      n_ac = 0;
    else if ((s & SLdac) != 0)  n_ac = b;
    else if ((s & SAnd) != 0)   n_ac = m_ac & m_dr;
    else if ((s & SAdd) != 0) begin
      n_ac = sum % 256;
      n_e  = sum / 256;
    end
    else if ((s & SLda) != 0)   n_ac = m_dr;
    else if ((s & SCom) != 0)   n_ac = 255 - m_ac;
    else if ((s & SIncac) != 0) n_ac = (m_ac + 1) % 256;
    else                        n_ac = m_ac;
    n_t = (s & SClrseq) != 0 ? 0 : (s & SIncseq) != 0 ? (m_t + 1) % 8 : m_t;
    wa = m_ar;

    @(posedge CLK);
    #1;
    if ((s & SWrite) != 0) mem[wa] = 8'(b);
    m_ar = n_ar; m_pc = n_pc; m_dr = n_dr; m_ir = n_ir; m_ac = n_ac; m_e = n_e; m_t = n_t;
    st = '0;
    I  = '0;
    @(negedge CLK);
  endtask

  // Read a register through the bus without clocking
  task automatic peek(input logic [7:0] isel, output int v);
    I = isel;
    #1;
    v = int'(MEM_WDATA);
    I = '0;
  endtask

  // Load AC/DR/PC from a value placed in memory at the current AR
  task automatic load_via_mem(input logic [22:0] s, input logic [7:0] val);
    mem[m_ar] = val;
    run(s, 8'h80);
  endtask

  int v;
  logic [22:0] rs;
  logic [7:0]  ri;

  initial begin
    for (int k = 0; k < 16; k++) mem[k] = 8'($urandom);
    st  = '0;
    I   = '0;
    RST = 1'b1;
    model_reset();
    #5;
    chk("reset_t", int'(T), 8'h01);
    chk("reset_d", int'(D), 8'h01);
    chk("reset_ac", int'(AC_Q), 0);
    chk("reset_ir", int'(IR_Q), 0);
    chk("reset_e", int'(E), 0);
    chk("reset_ar", int'(MEM_ADDR), 0);
    peek(8'h04, v);
    chk("reset_pc", v, 0);
    @(negedge CLK);
    RST = 1'b0;

    // Fetch
    load_via_mem(SLdpc, 8'h03);
    mem[3] = 8'h25;
    run(SClrseq, 8'h00);
    run(SLdar | SIncseq, 8'h04);
    run(SRead | SLdir | SIncpc | SIncseq, 8'h80);
    chk("fetch_ar", int'(MEM_ADDR), 3);
    chk("fetch_ir", int'(IR_Q), 8'h25);
    chk("fetch_t", int'(T), 8'h04);
    chk("fetch_d", int'(D), 8'h04);
    peek(8'h04, v);
    chk("fetch_pc", v, 4);

    // ADD with carry, then INCAC leaves E alone
    load_via_mem(SLdac, 8'hF0);
    load_via_mem(SLddr, 8'h20);
    run(SAdd, 8'h00);
    chk("add_ac", int'(AC_Q), 8'h10);
    chk("add_e", int'(E), 1);
    run(SIncac, 8'h00);
    chk("incac_ac", int'(AC_Q), 8'h11);
    chk("incac_e", int'(E), 1);

    // Priorities
    load_via_mem(SClrac | SLdac | SAdd, 8'h5A);
    chk("prio_ac", int'(AC_Q), 0);
    load_via_mem(SLdpc | SIncpc, 8'h09);
    peek(8'h04, v);
    chk("prio_pc", v, 9);
    run(SClrseq, 8'h00);
    for (int k = 0; k < 5; k++) run(SIncseq, 8'h00);
    chk("t5", int'(T), 8'h20);
    run(SClrseq | SIncseq, 8'h00);
    chk("prio_seq", int'(T), 8'h01);

    // Wraps
    load_via_mem(SLdpc, 8'h0F);
    run(SIncpc, 8'h00);
    peek(8'h04, v);
    chk("pc_wrap", v, 0);
    for (int k = 0; k < 8; k++) run(SIncseq, 8'h00);
    chk("seq_wrap", int'(T), 8'h01);

    // Bus conflict: AC beats PC
    load_via_mem(SLdac, 8'h77);
    load_via_mem(SLdpc, 8'h02);
    I = 8'h14;
    #1;
    chk("conflict_bus", int'(MEM_WDATA), 8'h77);
    chk("conflict_flag", int'(BUS_CONFLICT), 1);
    run(SLddr, 8'h14);
    peek(8'h08, v);
    chk("conflict_dr", v, 8'h77);

    // Asynchronous reset mid-instruction
    load_via_mem(SLdac, 8'hF0);
    load_via_mem(SLddr, 8'h20);
    run(SAdd, 8'h00);
    load_via_mem(SLdac, 8'h33);
    run(SClrseq, 8'h00);
    for (int k = 0; k < 3; k++) run(SIncseq, 8'h00);
    chk("pre_rst_t", int'(T), 8'h08);
    chk("pre_rst_ac", int'(AC_Q), 8'h33);
    chk("pre_rst_e", int'(E), 1);
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    chk("arst_ac", int'(AC_Q), 0);
    chk("arst_e", int'(E), 0);
    chk("arst_t", int'(T), 8'h01);
    chk("arst_ir", int'(IR_Q), 0);
    chk("arst_d", int'(D), 8'h01);
    chk("arst_ar", int'(MEM_ADDR), 0);
    peek(8'h04, v);
    chk("arst_pc", v, 0);
    peek(8'h08, v);
    chk("arst_dr", v, 0);
    RST = 1'b0;
    run(SIncseq | SIncpc, 8'h00);
    chk("post_rst_t", int'(T), 8'h02);
    peek(8'h04, v);
    chk("post_rst_pc", v, 1);

    // Randomized strobes and bus selects
    for (int n = 0; n < 600; n++) begin
      rs = '0;
      for (int k = 0; k < 23; k++) if ($urandom_range(0, 5) == 0) rs[k] = 1'b1;
      case ($urandom_range(0, 3))
        0: ri = 8'(1 << $urandom_range(0, 7));
        1: ri = 8'($urandom);
        2: ri = 8'h80;
        default: ri = 8'h00;
      endcase
      if ($urandom_range(0, 7) == 0) mem[$urandom_range(0, 15)] = 8'($urandom);
      run(rs, ri);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mano_datapath.md
Name: mano_datapath

Overview:
- Register-transfer datapath that executes the strobes issued by the control unit of the 8-bit basic computer.
- Holds AR, PC, DR, AC, IR, E and the sequence counter, and drives the common bus and the external memory port.
- Returns T (one-hot timing), D (decoded opcode), IR and AC to the control unit, closing the control/datapath loop.

Parameters:
- WORD_W, 8, data/bus width. The IR field split below assumes 8.
- ADDR_W, 4, address width of AR and PC. Loads take bus[ADDR_W-1:0].
- PC_RESET, 0, PC value after reset.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- LDAR, CLRAR, INCAR  input  1 each  AR load from bus / clear / increment.
- LDPC, CLRPC, INCPC  input  1 each  PC strobes.
- LDDR, CLRDR, INCDR  input  1 each  DR strobes.
- LDIR, CLRIR, INCIR  input  1 each  IR strobes.
- LDAC, CLRAC, INCAC  input  1 each  AC load from bus / clear / increment.
- AND, ADD, LDA, COM  input  1 each  ALU ops into AC.
- CLRSEQ, INCSEQ  input  1 each  sequence counter clear / advance.
- READ, WRITE  input  1 each  memory strobes.
- I  input  8  one-hot bus source select.
- MEM_RDATA  input  WORD_W  external memory read data, combinational from MEM_ADDR.
- MEM_ADDR  output  ADDR_W  equals AR.
- MEM_WDATA  output  WORD_W  equals bus.
- MEM_RE  output  1  equals READ.
- MEM_WE  output  1  equals WRITE.
- T  output  8  one-hot timing state T0..T7.
- D  output  8  one-hot decode of IR[6:4].
- IR_Q  output  WORD_W  IR contents.
- AC_Q  output  WORD_W  AC contents.
- E  output  1  carry flip-flop.
- BUS_CONFLICT  output  1  combinational; high when more than one I bit is set.

Behaviour:
- Reset (asynchronous, immediate, valid mid-instruction): AR=0, PC=PC_RESET, DR=0, AC=0, IR=0, E=0, T=8'h01. Combinational outputs follow: D=8'h01, MEM_* track AR/bus/strobes.
- Bus, combinational, sources selected by I:
  - I[1] = AR, zero-extended.
  - I[2] = PC, zero-extended.
  - I[3] = DR.
  - I[4] = AC.
  - I[5] = IR.
  - I[7] = MEM_RDATA.
  - I[0] or I[6] alone, or I=0: bus = 0.
  - Multiple bits set: the highest set index wins and BUS_CONFLICT=1.
- All register updates occur on the rising CLK edge using pre-edge bus and register values, so same-cycle transfers are safe (e.g. AR<=PC with INCPC; DR<=M with AC op).
- AR, PC, DR, IR priority per register: CLR > LD > INC. Increments wrap modulo 2^width (AR/PC 15->0, DR/IR 8'hFF->0).
- AC priority: CLRAC > LDAC > AND > ADD > LDA > COM > INCAC. Only the highest-priority asserted op takes effect.
  - AND: AC <= AC & DR.
  - ADD: {E,AC} <= AC + DR, 9-bit result, E = carry out.
  - LDA: AC <= DR.
  - COM: AC <= ~AC.
  - INCAC: AC <= AC+1, wraps; E unchanged.
- E changes only on ADD or reset.
- Sequence counter: CLRSEQ forces T0 and has priority over INCSEQ. INCSEQ advances one-hot T0->T1->…->T7->T0. With neither asserted, T holds. T is always exactly one-hot.
- D = one-hot decode of IR[6:4], combinational from the IR register.
- Memory: MEM_WE=WRITE, MEM_WDATA=bus, MEM_ADDR=AR (pre-edge value), so the write uses the AR value current in that cycle. No internal storage; READ has no effect on the bus unless I[7] is set.
- Holding: a register with no asserted strobe retains its value indefinitely.

Test Plan:
- Fetch: PC=3, MEM[3]=8'h25. T0: I[2], LDAR, INCSEQ. T1: I[7], READ, LDIR, INCPC, INCSEQ. Required: AR=3, IR=8'h25, PC=4, T=8'h04, D=8'h04.
- ADD carry: AC=8'hF0, DR=8'h20, pulse ADD. Required: AC=8'h10, E=1. Then pulse INCAC: AC=8'h11, E stays 1.
- Priority: assert CLRAC+LDAC+ADD with bus=8'h5A. Required: AC=0. Assert LDPC+INCPC with bus=8'h09. Required: PC=9. Assert CLRSEQ+INCSEQ at T5. Required: T=8'h01.
- Wrap: PC=15 with INCPC gives PC=0. Eight INCSEQ pulses from T0 return T to 8'h01.
- Bus conflict: I=8'h14 with AC=8'h77, PC=2. Required: bus=8'h77 (I[4] wins), BUS_CONFLICT=1. With LDDR asserted, DR=8'h77.
- Reset mid-operation: at T3 with AC=8'h33, E=1, raise RST asynchronously between edges. Required: all registers cleared immediately, T=8'h01, PC=PC_RESET. First edge after RST falls behaves normally.
